// File: rtl/decoder_pkg.sv
// Shared types for the decoder pipeline: the decode mode and the buffer occupancy state.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT  = 2'd0,
    MODE_THERMO  = 2'd1,
    MODE_ONECOLD = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_core.sv
// Combinational code-to-vector decoder with error flag; zero latency, no flow control.
// Out-of-range codes and the reserved mode both produce an all-zero vector with err set.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int SIZE    = 5,
  parameter int NUM_OUT = 2**SIZE
) (
  input  logic [SIZE-1:0]    inp_i,
  input  mode_e              mode_i,
  output logic [NUM_OUT-1:0] out_o,
  output logic               err_o
);

  logic [31:0] code;

  always_comb begin
    code  = 32'(inp_i);
    err_o = (code >= 32'(NUM_OUT)) || (mode_i == MODE_RSVD);
    out_o = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      case (mode_i)
        MODE_ONEHOT:  out_o[k] = (code == 32'(k));
        MODE_THERMO:  out_o[k] = (32'(k) <= code);
        MODE_ONECOLD: out_o[k] = (code != 32'(k));
        default:      out_o[k] = 1'b0;
      endcase
    end
    if (err_o) begin
      out_o = '0;
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Registered decoder with a one-entry skid buffer: 1-cycle latency, full throughput.
// ready_o is decoded from the state register only, so ready_i never reaches it combinationally.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int SIZE      = 5,
  parameter int NUM_OUT   = 2**SIZE,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [SIZE-1:0]      inp_i,
  input  logic [1:0]           mode_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [NUM_OUT-1:0]   out_o,
  output logic                 err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  input  logic                 clr_cnt_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic [NUM_OUT-1:0]   out_q, out_d, skid_q, skid_d, dec_vec;
  logic                 err_q, err_d, skid_err_q, skid_err_d, dec_err;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 in_xfer, out_xfer;

  decoder_core #(
    .SIZE    (SIZE),
    .NUM_OUT (NUM_OUT)
  ) u_core (
    .inp_i  (inp_i),
    .mode_i (mode_e'(mode_i)),
    .out_o  (dec_vec),
    .err_o  (dec_err)
  );

  assign ready_o   = (state_q != ST_FULL);
  assign valid_o   = (state_q != ST_EMPTY);
  assign out_o     = out_q;
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;
  assign in_xfer   = valid_i & ready_o;
  assign out_xfer  = valid_o & ready_i;

  // Output register is zeroed whenever it empties so idle outputs read as 0.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    err_d      = err_q;
    skid_d     = skid_q;
    skid_err_d = skid_err_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          out_d   = dec_vec;
          err_d   = dec_err;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          out_d = dec_vec;
          err_d = dec_err;
        end else if (in_xfer) begin
          skid_d     = dec_vec;
          skid_err_d = dec_err;
          state_d    = ST_FULL;
        end else if (out_xfer) begin
          out_d   = '0;
          err_d   = 1'b0;
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          out_d      = skid_q;
          err_d      = skid_err_q;
          skid_d     = '0;
          skid_err_d = 1'b0;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Clear wins over the old count but still records an error beat accepted alongside it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = (in_xfer && dec_err) ? ERR_CNT_W'(1) : '0;
    end else if (in_xfer && dec_err && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_EMPTY;
      out_q      <= '0;
      err_q      <= 1'b0;
      skid_q     <= '0;
      skid_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      err_q      <= err_d;
      skid_q     <= skid_d;
      skid_err_q <= skid_err_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decoder_pipe.sv
// Scoreboard bench: instance A uses defaults, instance B uses NUM_OUT=20 and ERR_CNT_W=2.
module tb_decoder_pipe;
  import decoder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [4:0]  a_inp, b_inp;
  logic [1:0]  a_mode, b_mode;
  logic        a_vld, a_rdyo, a_err, a_vldo, a_rdyi, a_clr;
  logic        b_vld, b_rdyo, b_err, b_vldo, b_rdyi, b_clr;
  logic [31:0] a_out;
  logic [19:0] b_out;
  logic [7:0]  a_cnt;
  logic [1:0]  b_cnt;

  decoder_pipe u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .inp_i(a_inp), .mode_i(a_mode), .valid_i(a_vld),
    .ready_o(a_rdyo), .out_o(a_out), .err_o(a_err), .valid_o(a_vldo), .ready_i(a_rdyi),
    .clr_cnt_i(a_clr), .err_cnt_o(a_cnt)
  );

  decoder_pipe #(.SIZE(5), .NUM_OUT(20), .ERR_CNT_W(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .inp_i(b_inp), .mode_i(b_mode), .valid_i(b_vld),
    .ready_o(b_rdyo), .out_o(b_out), .err_o(b_err), .valid_o(b_vldo), .ready_i(b_rdyi),
    .clr_cnt_i(b_clr), .err_cnt_o(b_cnt)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] vec;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        m_e;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] a_hold;
  logic        a_stalled;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_a(input logic [4:0] c, input logic [1:0] m, input logic [31:0] eo, input logic ee);
    int n = 0;
    while (!a_rdyo && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!a_rdyo) begin
      chk("a_send_timeout", 32'(a_rdyo), 32'd1);
      return;
    end
    a_inp = c; a_mode = m; a_vld = 1'b1;
    q_a.push_back('{err: ee, vec: eo});
    @(posedge clk); #1;
    a_vld = 1'b0; a_inp = 5'(~c); a_mode = 2'(~m);
  endtask

  task automatic send_b(input logic [4:0] c, input logic [1:0] m, input logic [19:0] eo, input logic ee);
    int n = 0;
    while (!b_rdyo && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!b_rdyo) begin
      chk("b_send_timeout", 32'(b_rdyo), 32'd1);
      return;
    end
    b_inp = c; b_mode = m; b_vld = 1'b1;
    q_b.push_back('{err: ee, vec: 32'(eo)});
    @(posedge clk); #1;
    b_vld = 1'b0; b_inp = 5'(~c); b_mode = 2'(~m);
  endtask

  task automatic drain();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("a_drain_left", 32'(q_a.size()), 32'd0);
    chk("b_drain_left", 32'(q_b.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    a_inp = '0; a_mode = '0; a_vld = 1'b0; a_rdyi = 1'b1; a_clr = 1'b0;
    b_inp = '0; b_mode = '0; b_vld = 1'b0; b_rdyi = 1'b1; b_clr = 1'b0;
    a_hold = '0; a_stalled = 1'b0;
    #2 rst_n = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (a_stalled && rst_n) chk("a_hold_out", a_out, a_hold);
        if (a_vldo && a_rdyi) begin
          if (q_a.size() == 0) chk("a_unexpected_beat", 32'(a_vldo), 32'd0);
          else begin
            m_e = q_a.pop_front();
            chk("a_out", a_out, m_e.vec);
            chk("a_err", 32'(a_err), 32'(m_e.err));
          end
        end else if (!a_vldo) begin
          chk("a_idle_out", a_out, 32'd0);
          chk("a_idle_err", 32'(a_err), 32'd0);
        end
        a_stalled = a_vldo && !a_rdyi && rst_n;
        a_hold    = a_out;
        if (b_vldo && b_rdyi) begin
          if (q_b.size() == 0) chk("b_unexpected_beat", 32'(b_vldo), 32'd0);
          else begin
            m_e = q_b.pop_front();
            chk("b_out", 32'(b_out), m_e.vec);
            chk("b_err", 32'(b_err), 32'(m_e.err));
          end
        end else if (!b_vldo) begin
          chk("b_idle_out", 32'(b_out), 32'd0);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_rdy", 32'(a_rdyo), 32'd1);
    chk("rst_a_vld", 32'(a_vldo), 32'd0);
    chk("rst_a_out", a_out, 32'd0);
    chk("rst_a_cnt", 32'(a_cnt), 32'd0);
    chk("rst_b_rdy", 32'(b_rdyo), 32'd1);
    chk("rst_b_cnt", 32'(b_cnt), 32'd0);

    // First beat goes in on the very first edge after release.
    rst_n = 1'b1;
    send_a(5'd0, MODE_ONEHOT, 32'h0000_0001, 1'b0);
    chk("lat1_vld", 32'(a_vldo), 32'd1);
    chk("lat1_out", a_out, 32'h0000_0001);
    send_a(5'd31, MODE_ONEHOT, 32'h8000_0000, 1'b0);
    chk("b2b_out", a_out, 32'h8000_0000);
    send_a(5'd3, MODE_THERMO, 32'h0000_000F, 1'b0);
    send_a(5'd3, MODE_ONECOLD, 32'hFFFF_FFF7, 1'b0);
    send_a(5'd31, MODE_THERMO, 32'hFFFF_FFFF, 1'b0);
    chk("a_cnt_no_err", 32'(a_cnt), 32'd0);
    drain();

    a_rdyi = 1'b0;
    send_a(5'd3, MODE_THERMO, 32'h0000_000F, 1'b0);
    send_a(5'd2, MODE_ONEHOT, 32'h0000_0004, 1'b0);
    chk("bp_rdy_full", 32'(a_rdyo), 32'd0);
    chk("bp_out_first", a_out, 32'h0000_000F);
    a_vld = 1'b1; a_inp = 5'd7; a_mode = MODE_ONEHOT;
    repeat (3) @(posedge clk);
    #1;
    a_vld = 1'b0;
    chk("bp_hold_out", a_out, 32'h0000_000F);
    chk("bp_hold_rdy", 32'(a_rdyo), 32'd0);
    a_rdyi = 1'b1;
    drain();

    a_rdyi = 1'b0;
    send_a(5'd5, MODE_ONEHOT, 32'h0000_0020, 1'b0);
    send_a(5'd6, MODE_ONEHOT, 32'h0000_0040, 1'b0);
    chk("full_rdy", 32'(a_rdyo), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(a_vldo), 32'd0);
    chk("arst_out", a_out, 32'd0);
    chk("arst_rdy", 32'(a_rdyo), 32'd1);
    q_a.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_rdyi = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_a(5'd9, MODE_ONEHOT, 32'h0000_0200, 1'b0);
    drain();

    send_b(5'd25, MODE_ONEHOT, 20'h0, 1'b1);
    chk("b_cnt_1", 32'(b_cnt), 32'd1);
    send_b(5'd0, MODE_RSVD, 20'h0, 1'b1);
    chk("b_cnt_2", 32'(b_cnt), 32'd2);
    send_b(5'd3, MODE_ONEHOT, 20'h0_0008, 1'b0);
    chk("b_cnt_good", 32'(b_cnt), 32'd2);
    send_b(5'd19, MODE_THERMO, 20'hF_FFFF, 1'b0);
    send_b(5'd20, MODE_ONEHOT, 20'h0, 1'b1);
    chk("b_cnt_3", 32'(b_cnt), 32'd3);
    send_b(5'd31, MODE_ONECOLD, 20'h0, 1'b1);
    send_b(5'd24, MODE_THERMO, 20'h0, 1'b1);
    chk("b_cnt_sat", 32'(b_cnt), 32'd3);
    b_clr = 1'b1;
    send_b(5'd22, MODE_ONEHOT, 20'h0, 1'b1);
    b_clr = 1'b0;
    chk("b_clr_with_err", 32'(b_cnt), 32'd1);
    b_clr = 1'b1;
    @(posedge clk); #1;
    b_clr = 1'b0;
    chk("b_clr_only", 32'(b_cnt), 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 Parameter SIZE, default 5, code width in bits.
REQ-002 Parameter NUM_OUT, default 2**SIZE, number of decoded outputs; legal range 2..2**SIZE.
REQ-003 Parameter ERR_CNT_W, default 8, width of error counter.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 inp_i  input  SIZE  code to decode.
REQ-007 mode_i  input  2  decode mode (package enum), sampled with inp_i.
REQ-008 valid_i  input  1  input beat valid.
REQ-009 ready_o  output  1  block can accept a beat.
REQ-010 out_o  output  NUM_OUT  decoded vector, packed, bit k = output k.
REQ-011 err_o  output  1  current output beat is an error beat.
REQ-012 valid_o  output  1  output beat valid.
REQ-013 ready_i  input  1  downstream accepts beat.
REQ-014 clr_cnt_i  input  1  synchronous clear of error counter.
REQ-015 err_cnt_o  output  ERR_CNT_W  saturating count of accepted error beats.

Function
REQ-016 Input transfer occurs when valid_i and ready_o are both 1; output transfer when valid_o and ready_i are both 1.
REQ-017 Modes: ONEHOT(0) out[k]=(k==inp); THERMO(1) out[k]=(k<=inp); ONECOLD(2) out[k]=(k!=inp); mode 3 reserved.
REQ-018 Beat is an error beat if inp_i >= NUM_OUT or mode_i == 3; its out_o = all zeros, err_o = 1.
REQ-019 Storage: output register plus one skid entry; FSM states EMPTY, ONE, FULL.
REQ-020 EMPTY: input transfer -> ONE.
REQ-021 ONE: input without output transfer -> FULL; output without input -> EMPTY; both or neither -> ONE.
REQ-022 FULL: output transfer moves skid entry into output register -> ONE; no input accepted in FULL.
REQ-023 ready_o = 1 exactly in EMPTY and ONE; driven only from registers, no combinational path from ready_i.
REQ-024 valid_o = 1 exactly in ONE and FULL.
REQ-025 Latency: beat accepted at edge N appears on out_o/valid_o after edge N when output register is free or being drained that cycle; else after skid drains.
REQ-026 Throughput: one beat per cycle sustained while ready_i = 1.
REQ-027 Ordering: beats leave in acceptance order; none dropped or duplicated.
REQ-028 out_o and err_o held stable while valid_o = 1 and ready_i = 0.
REQ-029 out_o = 0 and err_o = 0 whenever valid_o = 0.
REQ-030 err_cnt_o increments by 1 per accepted error beat, saturates at 2**ERR_CNT_W-1.
REQ-031 clr_cnt_i = 1 sets err_cnt_o to 0; with simultaneous accepted error beat result is 1.
REQ-032 Inputs ignored while valid_i = 0; mode and code captured at acceptance only.

Reset
REQ-033 Reset asserts asynchronously: state EMPTY, valid_o 0, out_o 0, err_o 0, err_cnt_o 0, ready_o 1.
REQ-034 Reset mid-operation discards both stored beats; no output transfer reported for them.
REQ-035 First input transfer possible on first rising edge after rst_ni deasserts.

Structure
REQ-036 Package decoder_pkg holds mode enum (MODE_ONEHOT, MODE_THERMO, MODE_ONECOLD, MODE_RSVD) and FSM state enum.
REQ-037 Combinational sub-module decoder_core (SIZE, NUM_OUT) maps code+mode to vector and error flag; decoded at input, stored registered.

Verification
REQ-038 SIZE=5 defaults, ready_i=1, send inp 0x00,0x1F ONEHOT -> out_o 0x00000001 then 0x80000000 on consecutive cycles, latency 1.
REQ-039 THERMO inp 3 -> out_o 0x0000000F; ONECOLD inp 3 -> out_o 0xFFFFFFF7, err_o 0.
REQ-040 NUM_OUT=20, inp 25 ONEHOT -> out_o 0, err_o 1, err_cnt_o 1; mode 3 inp 0 -> err_o 1, err_cnt_o 2.
REQ-041 Backpressure: ready_i=0, send beats A,B -> ready_o 0 after B, out_o holds A; ready_i=1 -> A then B, no loss.
REQ-042 ERR_CNT_W=2, five error beats -> err_cnt_o saturates at 3; clr_cnt_i with error beat same cycle -> 1.
REQ-043 Assert rst_ni low in FULL -> valid_o 0, out_o 0, ready_o 1 immediately, no stale beat after release.
